// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / InvSubBytes engine: substitutes LANES bytes of a
// 128-bit state per clock, with valid/ready handshakes on input and output.
module sub_bytes_engine #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam int unsigned N_CHUNKS = 16 / LANES;
  localparam int unsigned CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int unsigned CHUNK_W  = 8 * LANES;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16))
  begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be one of 1, 2, 4, 8, 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [127:0]       data_q;
  logic               mode_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_d;
  logic               out_valid_d;
  logic               accept_c;
  logic [CHUNK_W-1:0] chunk_c;
  logic [CHUNK_W-1:0] sub_c;
  logic [127:0]       next_data_c;

  assign accept_c = (state_q == IDLE) && in_valid && in_ready;
  assign data_out = data_q;

  // Select the chunk currently being substituted
  always_comb begin
    chunk_c = '0;
    for (int k = 0; k < int'(N_CHUNKS); k++) begin
      if (cnt_q == CNT_W'(k)) chunk_c = data_q[k*CHUNK_W +: CHUNK_W];
    end
  end

  // One independent lookup per lane; the mode is shared by the whole transaction
  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    assign sub_c[8*l +: 8] = mode_q ? inv_sbox(chunk_c[8*l +: 8])
                                    : fwd_sbox(chunk_c[8*l +: 8]);
  end

  // Write the substituted chunk back in place
  always_comb begin
    next_data_c = data_q;
    for (int k = 0; k < int'(N_CHUNKS); k++) begin
      if (cnt_q == CNT_W'(k)) next_data_c[k*CHUNK_W +: CHUNK_W] = sub_c;
    end
  end

  // Next-state logic; handshake flags are registered from the next state
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE:    if (accept_c) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_CHUNK) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // State register is frozen outside BUSY except for the accept load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept_c) begin
      data_q <= data_in;
      mode_q <= inv;
      cnt_q  <= '0;
    end else if (state_q == BUSY) begin
      data_q <= next_data_c;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine: one instance per legal LANES value,
// directed vectors plus a forward/inverse random round trip.
module tb_sub_bytes_engine;

  localparam int NDUT = 5;

  localparam logic [127:0] INV_IN  = 128'h00000000000000DFCCFF194EA3562300;
  localparam logic [127:0] INV_EXP = 128'h52525252525252EF277D8EB671B93252;
  localparam logic [127:0] FWD_IN  = 128'h0000000000000000000000000001FF5300;
  localparam logic [127:0] FWD_EXP = 128'h636363636363636363636363_7C16ED63;

  typedef struct {
    int           dut;
    logic [127:0] data;
    logic         chk;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NDUT-1:0] in_valid = '0;
  logic [NDUT-1:0] inv = '0;
  logic [NDUT-1:0] ready_cmd = '1;
  logic [NDUT-1:0] in_ready;
  logic [NDUT-1:0] out_valid;
  logic [NDUT-1:0] out_ready;
  logic [127:0]    data_in [NDUT];
  logic [127:0]    data_out [NDUT];
  logic            rand_en = 1'b0;
  logic            rnd_bit = 1'b1;
  logic [NDUT-1:0] ov_seen = '0;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int accept_edge [NDUT];

  exp_t         sb_q[$];
  logic [127:0] fwd_res[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  assign out_ready = ready_cmd & (rand_en ? {NDUT{rnd_bit}} : {NDUT{1'b1}});

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sub_bytes_engine #(.LANES(1 << g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .data_in  (data_in[g]),
      .inv      (inv[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .data_out (data_out[g])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept
  task automatic send(input int d, input logic [127:0] v, input logic m,
                      input logic [127:0] exp, input logic chk);
    int n;
    n = 0;
    data_in[d]  = v;
    inv[d]      = m;
    in_valid[d] = 1'b1;
    #1;
    while (!in_ready[d] && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready[d]) begin
      check($sformatf("accept_timeout dut%0d", d), 128'(in_ready[d]), 128'(1));
    end else begin
      sb_q.push_back('{dut: d, data: exp, chk: chk});
      accept_edge[d] = cyc + 1;
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
    data_in[d]  = {$urandom, $urandom, $urandom, $urandom};
    inv[d]      = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 128'(sb_q.size()), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  // Monitor: latency on the rising out_valid, data on each output handshake
  always @(negedge clk) begin : mon
    exp_t e;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      if (out_valid[d] && !ov_seen[d]) begin
        ov_seen[d] = 1'b1;
        check($sformatf("latency dut%0d", d), 128'(cyc - accept_edge[d]), 128'(16 >> d));
      end
      if (!out_valid[d]) ov_seen[d] = 1'b0;
      if (out_valid[d] && out_ready[d]) begin
        if (sb_q.size() == 0 || sb_q[0].dut != d) begin
          check($sformatf("spurious_out dut%0d", d), 128'(out_valid[d]), 128'(0));
        end else begin
          e = sb_q.pop_front();
          if (e.chk) check($sformatf("data dut%0d", d), data_out[d], e.data);
          else fwd_res.push_back(data_out[d]);
        end
      end
    end
  end

  initial begin
    logic [127:0] w;
    logic [127:0] orig[$];
    int n;
    for (int i = 0; i < NDUT; i++) begin
      data_in[i]     = '0;
      accept_edge[i] = 0;
    end

    // Reset values, during and after reset
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_in_ready dut%0d", d), 128'(in_ready[d]), 128'(1));
      check($sformatf("rst_out_valid dut%0d", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("rst_data dut%0d", d), data_out[d], 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("post_rst_in_ready dut%0d", d), 128'(in_ready[d]), 128'(1));
      check($sformatf("post_rst_out_valid dut%0d", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("post_rst_data dut%0d", d), data_out[d], 128'h0);
    end
    @(negedge clk);

    // Inverse mode and the matching forward vector on LANES=4
    send(2, INV_IN, 1'b1, INV_EXP, 1'b1);
    drain();
    send(2, INV_EXP, 1'b0, INV_IN, 1'b1);
    drain();

    // Forward mode on every legal LANES
    for (int d = 0; d < NDUT; d++) begin
      send(d, FWD_IN, 1'b0, FWD_EXP, 1'b1);
      drain();
    end

    // Backpressure with noisy inputs while the result is held
    ready_cmd[2] = 1'b0;
    send(2, FWD_IN, 1'b0, FWD_EXP, 1'b1);
    #1;
    n = 0;
    while (!out_valid[2] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bp_out_valid_rise", 128'(out_valid[2]), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      data_in[2]  = {$urandom, $urandom, $urandom, $urandom};
      inv[2]      = 1'($urandom_range(0, 1));
      in_valid[2] = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("bp_data c%0d", i), data_out[2], FWD_EXP);
      check($sformatf("bp_in_ready c%0d", i), 128'(in_ready[2]), 128'(0));
      check($sformatf("bp_out_valid c%0d", i), 128'(out_valid[2]), 128'(1));
    end
    @(negedge clk);
    in_valid[2]  = 1'b0;
    ready_cmd[2] = 1'b1;
    #1;
    check("bp_hold_before_hs", 128'(out_valid[2]), 128'(1));
    @(negedge clk);
    #1;
    check("bp_in_ready_after_hs", 128'(in_ready[2]), 128'(1));
    check("bp_out_valid_after_hs", 128'(out_valid[2]), 128'(0));
    @(negedge clk);

    // Reset in the 7th BUSY cycle of LANES=1 discards the transaction
    send(0, FWD_IN, 1'b0, FWD_EXP, 1'b1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete(sb_q.size() - 1);
    #1;
    check("midrst_in_ready", 128'(in_ready[0]), 128'(1));
    check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    check("midrst_data", data_out[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, INV_EXP, 1'b0, INV_IN, 1'b1);
    drain();

    // Random round trip on LANES=4 with random gaps and backpressure
    rand_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      orig.push_back(w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(2, w, 1'b0, 128'h0, 1'b0);
    end
    drain();
    check("fwd_count", 128'(fwd_res.size()), 128'(200));
    for (int i = 0; i < fwd_res.size() && i < orig.size(); i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(2, fwd_res[i], 1'b1, orig[i], 1'b1);
    end
    drain();
    rand_en = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("final_idle", 128'(out_valid[2]), 128'(0));
    check("final_queue", 128'(sb_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
